// File: rtl/stateful_cfg_arbiter_if.sv
// stateful_cfg_arbiter_if: packet stream and control-plane config port bundle for stateful_cfg_arbiter.
interface stateful_cfg_arbiter_if #(
    parameter int IDX_W = 4
);
    logic             pkt_vld_in;
    logic [511:0]     pkt_data_in;
    logic             pkt_vld_out;
    logic [511:0]     pkt_data_out;
    logic [15:0]      action_out;
    logic [7:0]       state_out;
    logic             cfg_req;
    logic             cfg_wr;
    logic [IDX_W-1:0] cfg_addr;
    logic [31:0]      cfg_wdata;
    logic             cfg_ack;
    logic [31:0]      cfg_rdata;
    modport master (
        output pkt_vld_in, pkt_data_in, cfg_req, cfg_wr, cfg_addr, cfg_wdata,
        input  pkt_vld_out, pkt_data_out, action_out, state_out, cfg_ack, cfg_rdata
    );
    modport slave (
        input  pkt_vld_in, pkt_data_in, cfg_req, cfg_wr, cfg_addr, cfg_wdata,
        output pkt_vld_out, pkt_data_out, action_out, state_out, cfg_ack, cfg_rdata
    );
endinterface

// File: rtl/stateful_cfg_arbiter.sv
// stateful_cfg_arbiter: per-flow state table shared by a 2-stage packet read-modify-write pipeline
// and a bubble-only config port. Option macro STATEFUL_CFG_CLR_ON_RD_EN makes config reads clear state.
module stateful_cfg_arbiter #(
    parameter int IDX_W   = 4,
    parameter int KEY_LSB = 0
) (
    input logic                   clk,
    input logic                   reset,
    stateful_cfg_arbiter_if.slave bus
);
    localparam int DEPTH = 2 ** IDX_W;
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, ACK} state_e;
    state_e           st_q, st_d;
    logic             skip_q, skip_d;
    logic             cfg_wr_q, cfg_wr_d;
    logic [IDX_W-1:0] cfg_addr_q, cfg_addr_d;
    logic [31:0]      cfg_wdata_q, cfg_wdata_d;
    logic [31:0]      cfg_rdata_q, cfg_rdata_d;
    logic [31:0]      tbl_q [DEPTH];
    logic [31:0]      tbl_d [DEPTH];
    logic             s0_vld_q, s0_vld_d;
    logic [511:0]     s0_data_q, s0_data_d;
    logic [IDX_W-1:0] s0_idx_q, s0_idx_d;
    logic [31:0]      s0_ent_q, s0_ent_d;
    logic             vld_out_q, vld_out_d;
    logic [511:0]     data_out_q, data_out_d;
    logic [15:0]      act_out_q, act_out_d;
    logic [7:0]       st_out_q, st_out_d;
    logic [7:0]       new_state;
    logic [IDX_W-1:0] pkt_idx;
    logic             slot_free;
    always_comb begin
        new_state = (s0_ent_q[31:24] == 8'hFF) ? 8'hFF : s0_ent_q[31:24] + 8'd1;
        pkt_idx   = bus.pkt_data_in[KEY_LSB +: IDX_W];
        slot_free = !bus.pkt_vld_in && !s0_vld_q;
        tbl_d     = tbl_q;
        if (s0_vld_q)
            tbl_d[s0_idx_q] = {new_state, s0_ent_q[23:0]};
        if (st_q == ACCESS && cfg_wr_q)
            tbl_d[cfg_addr_q] = cfg_wdata_q;
`ifdef STATEFUL_CFG_CLR_ON_RD_EN
        if (st_q == ACCESS && !cfg_wr_q)
            tbl_d[cfg_addr_q] = {8'h00, tbl_q[cfg_addr_q][23:0]};
`endif
        // S0 reads the post-write table so same-cycle write-backs and config accesses are forwarded
        s0_vld_d    = bus.pkt_vld_in;
        s0_data_d   = bus.pkt_data_in;
        s0_idx_d    = pkt_idx;
        s0_ent_d    = tbl_d[pkt_idx];
        vld_out_d   = s0_vld_q;
        data_out_d  = s0_vld_q ? s0_data_q : '0;
        act_out_d   = (s0_vld_q && new_state >= s0_ent_q[23:16]) ? s0_ent_q[15:0] : '0;
        st_out_d    = s0_vld_q ? new_state : '0;
        st_d        = st_q;
        skip_d      = (st_q == ACK);
        cfg_wr_d    = cfg_wr_q;
        cfg_addr_d  = cfg_addr_q;
        cfg_wdata_d = cfg_wdata_q;
        cfg_rdata_d = (st_q == ACCESS && !cfg_wr_q) ? tbl_q[cfg_addr_q] : cfg_rdata_q;
        unique case (st_q)
            IDLE: begin
                if (bus.cfg_req && !skip_q) begin
                    st_d        = WAIT;
                    cfg_wr_d    = bus.cfg_wr;
                    cfg_addr_d  = bus.cfg_addr;
                    cfg_wdata_d = bus.cfg_wdata;
                end
            end
            WAIT:    st_d = slot_free ? ACCESS : WAIT;
            ACCESS:  st_d = ACK;
            default: st_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q        <= IDLE;
            skip_q      <= 1'b0;
            cfg_wr_q    <= 1'b0;
            cfg_addr_q  <= '0;
            cfg_wdata_q <= '0;
            cfg_rdata_q <= '0;
            for (int i = 0; i < DEPTH; i++) tbl_q[i] <= '0;
            s0_vld_q    <= 1'b0;
            s0_data_q   <= '0;
            s0_idx_q    <= '0;
            s0_ent_q    <= '0;
            vld_out_q   <= 1'b0;
            data_out_q  <= '0;
            act_out_q   <= '0;
            st_out_q    <= '0;
        end else begin
            st_q        <= st_d;
            skip_q      <= skip_d;
            cfg_wr_q    <= cfg_wr_d;
            cfg_addr_q  <= cfg_addr_d;
            cfg_wdata_q <= cfg_wdata_d;
            cfg_rdata_q <= cfg_rdata_d;
            tbl_q       <= tbl_d;
            s0_vld_q    <= s0_vld_d;
            s0_data_q   <= s0_data_d;
            s0_idx_q    <= s0_idx_d;
            s0_ent_q    <= s0_ent_d;
            vld_out_q   <= vld_out_d;
            data_out_q  <= data_out_d;
            act_out_q   <= act_out_d;
            st_out_q    <= st_out_d;
        end
    end
    assign bus.pkt_vld_out  = vld_out_q;
    assign bus.pkt_data_out = data_out_q;
    assign bus.action_out   = act_out_q;
    assign bus.state_out    = st_out_q;
    assign bus.cfg_ack      = (st_q == ACK);
    assign bus.cfg_rdata    = cfg_rdata_q;
endmodule

// File: tb/tb_stateful_cfg_arbiter.sv
// tb_stateful_cfg_arbiter: directed tests for the stateful table arbiter.
// Expected values are hand-computed from the entry layout {state, thresh, action}.
module tb_stateful_cfg_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_chk = 0;
    int n_pass = 0;
    stateful_cfg_arbiter_if #(.IDX_W(4)) bus();
    stateful_cfg_arbiter #(.IDX_W(4), .KEY_LSB(0)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Holds cfg_req until ack, keeps it high through the following cycle, then drops it
    task automatic cfg_op(input logic wr, input logic [3:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output int lat);
        bus.cfg_req = 1'b1; bus.cfg_wr = wr; bus.cfg_addr = a; bus.cfg_wdata = wd;
        lat = -1; rd = '0;
        for (int i = 1; i <= 40 && lat < 0; i++) begin
            tick();
            if (bus.cfg_ack) begin lat = i; rd = bus.cfg_rdata; end
        end
        tick(); tick();
        bus.cfg_req = 1'b0;
    endtask

    task automatic test_reset();
        bus.pkt_vld_in = 1'b0; bus.pkt_data_in = '0;
        bus.cfg_req = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        repeat (3) tick();
        n_chk++; if (bus.pkt_vld_out !== 1'b0) $display("FAIL rst_vld: got %b want 0", bus.pkt_vld_out); else n_pass++;
        n_chk++; if (bus.pkt_data_out !== '0) $display("FAIL rst_data: got nonzero want 0"); else n_pass++;
        n_chk++; if (bus.action_out !== 16'h0) $display("FAIL rst_action: got %h want 0000", bus.action_out); else n_pass++;
        n_chk++; if (bus.state_out !== 8'h0) $display("FAIL rst_state: got %h want 00", bus.state_out); else n_pass++;
        n_chk++; if (bus.cfg_ack !== 1'b0) $display("FAIL rst_ack: got %b want 0", bus.cfg_ack); else n_pass++;
        n_chk++; if (bus.cfg_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", bus.cfg_rdata); else n_pass++;
        reset = 1'b1;
        tick();
        bus.pkt_vld_in = 1'b1; bus.pkt_data_in = 512'h2;
        tick();
        bus.pkt_vld_in = 1'b0; bus.pkt_data_in = '0;
        n_chk++; if (bus.pkt_vld_out !== 1'b0) $display("FAIL rst_pkt_early: got %b want 0", bus.pkt_vld_out); else n_pass++;
        tick();
        n_chk++; if (bus.pkt_vld_out !== 1'b1) $display("FAIL rst_pkt_vld: got %b want 1", bus.pkt_vld_out); else n_pass++;
        n_chk++; if (bus.state_out !== 8'h01) $display("FAIL rst_pkt_state: got %h want 01", bus.state_out); else n_pass++;
        n_chk++; if (bus.pkt_data_out !== 512'h2) $display("FAIL rst_pkt_data: got %h want 2", bus.pkt_data_out[31:0]); else n_pass++;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        int lat;
        logic seen;
        logic [7:0]  es [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [15:0] ea [4] = '{16'h0000, 16'h0000, 16'hBEEF, 16'hBEEF};
        cfg_op(1'b1, 4'd2, 32'h0003BEEF, rd, lat);
        n_chk++; if (lat !== 3) $display("FAIL b2b_cfg_lat: got %0d want 3", lat); else n_pass++;
        seen = 1'b0;
        repeat (4) begin tick(); if (bus.cfg_ack) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) $display("FAIL b2b_no_reack: got %b want 0", seen); else n_pass++;
        for (int i = 0; i < 6; i++) begin
            bus.pkt_vld_in = (i < 4); bus.pkt_data_in = (i < 4) ? 512'h4322 : '0;
            tick();
            if (i >= 1 && i <= 4) begin
                n_chk++; if (bus.pkt_vld_out !== 1'b1) $display("FAIL b2b_vld%0d: got %b want 1", i, bus.pkt_vld_out); else n_pass++;
                n_chk++; if (bus.state_out !== es[i-1]) $display("FAIL b2b_state%0d: got %h want %h", i, bus.state_out, es[i-1]); else n_pass++;
                n_chk++; if (bus.action_out !== ea[i-1]) $display("FAIL b2b_action%0d: got %h want %h", i, bus.action_out, ea[i-1]); else n_pass++;
                n_chk++; if (bus.pkt_data_out !== 512'h4322) $display("FAIL b2b_data%0d: got %h want 4322", i, bus.pkt_data_out[31:0]); else n_pass++;
            end else begin
                n_chk++; if (bus.pkt_vld_out !== 1'b0 || bus.state_out !== 8'h0 || bus.action_out !== 16'h0)
                    $display("FAIL b2b_idle%0d: got vld=%b st=%h act=%h want 0/00/0000", i, bus.pkt_vld_out, bus.state_out, bus.action_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_read_twice();
        logic [31:0] rd;
        int lat;
`ifdef STATEFUL_CFG_CLR_ON_RD_EN
        logic [31:0] exp2 = 32'h0003BEEF;
`else
        logic [31:0] exp2 = 32'h0403BEEF;
`endif
        cfg_op(1'b0, 4'd2, 32'h0, rd, lat);
        n_chk++; if (lat !== 3 || rd !== 32'h0403BEEF) $display("FAIL rd1: got lat=%0d data=%h want 3/0403beef", lat, rd); else n_pass++;
        cfg_op(1'b0, 4'd2, 32'h0, rd, lat);
        n_chk++; if (lat !== 3 || rd !== exp2) $display("FAIL rd2: got lat=%0d data=%h want 3/%h", lat, rd, exp2); else n_pass++;
    endtask

    task automatic test_saturate();
        logic [31:0] rd;
        int lat;
        cfg_op(1'b1, 4'd2, 32'hFE00_1234, rd, lat);
        for (int i = 0; i < 5; i++) begin
            bus.pkt_vld_in = (i < 3); bus.pkt_data_in = 512'h4322;
            tick();
            if (i >= 1 && i <= 3) begin
                n_chk++; if (bus.pkt_vld_out !== 1'b1 || bus.state_out !== 8'hFF || bus.action_out !== 16'h1234)
                    $display("FAIL sat%0d: got vld=%b st=%h act=%h want 1/ff/1234", i, bus.pkt_vld_out, bus.state_out, bus.action_out);
                else n_pass++;
            end
        end
    endtask

    task automatic test_starve();
        logic [31:0] rd;
        int lat;
        int ack_dist;
        logic early;
        cfg_op(1'b1, 4'd2, 32'h0003_1234, rd, lat);
        bus.cfg_req = 1'b1; bus.cfg_wr = 1'b0; bus.cfg_addr = 4'd2;
        early = 1'b0;
        for (int i = 0; i < 8; i++) begin
            bus.pkt_vld_in = (i < 6); bus.pkt_data_in = 512'h4322;
            tick();
            if (bus.cfg_ack) early = 1'b1;
            if (i >= 1 && i <= 6) begin
                n_chk++; if (bus.pkt_vld_out !== 1'b1 || bus.state_out !== 8'(i) || bus.action_out !== ((i >= 3) ? 16'h1234 : 16'h0))
                    $display("FAIL starve_pkt%0d: got vld=%b st=%h act=%h want 1/%h", i, bus.pkt_vld_out, bus.state_out, bus.action_out, 8'(i));
                else n_pass++;
            end
        end
        n_chk++; if (early !== 1'b0) $display("FAIL starve_early_ack: got %b want 0", early); else n_pass++;
        ack_dist = -1;
        for (int k = 1; k <= 20 && ack_dist < 0; k++) begin
            tick();
            if (bus.cfg_ack) begin ack_dist = k + 2; rd = bus.cfg_rdata; end
        end
        n_chk++; if (ack_dist < 3) $display("FAIL starve_ack: got dist=%0d want >=3", ack_dist); else n_pass++;
        n_chk++; if (rd !== 32'h0603_1234) $display("FAIL starve_rdata: got %h want 06031234", rd); else n_pass++;
        tick(); tick();
        bus.cfg_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd;
        int lat;
        logic seen;
        bus.cfg_req = 1'b1; bus.cfg_wr = 1'b0; bus.cfg_addr = 4'd2;
        bus.pkt_vld_in = 1'b1; bus.pkt_data_in = 512'h4322;
        repeat (3) tick();
        #2 reset = 1'b0;
        #1;
        n_chk++; if (bus.pkt_vld_out !== 1'b0 || bus.state_out !== 8'h0 || bus.cfg_ack !== 1'b0 || bus.cfg_rdata !== 32'h0)
            $display("FAIL wrst_outs: got vld=%b st=%h ack=%b rd=%h want all 0", bus.pkt_vld_out, bus.state_out, bus.cfg_ack, bus.cfg_rdata);
        else n_pass++;
        tick(); tick();
        reset = 1'b1;
        bus.cfg_req = 1'b0; bus.pkt_vld_in = 1'b0; bus.pkt_data_in = '0;
        seen = 1'b0;
        repeat (5) begin tick(); if (bus.cfg_ack || bus.pkt_vld_out) seen = 1'b1; end
        n_chk++; if (seen !== 1'b0) $display("FAIL wrst_quiet: got %b want 0", seen); else n_pass++;
        cfg_op(1'b0, 4'd2, 32'h0, rd, lat);
        n_chk++; if (lat !== 3 || rd !== 32'h0) $display("FAIL wrst_rd2: got lat=%0d data=%h want 3/0", lat, rd); else n_pass++;
        bus.pkt_vld_in = 1'b1; bus.pkt_data_in = 512'h4322;
        tick();
        bus.pkt_vld_in = 1'b0;
        tick();
        n_chk++; if (bus.pkt_vld_out !== 1'b1 || bus.state_out !== 8'h01 || bus.action_out !== 16'h0)
            $display("FAIL wrst_pkt: got vld=%b st=%h act=%h want 1/01/0000", bus.pkt_vld_out, bus.state_out, bus.action_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_read_twice();
        test_saturate();
        test_starve();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
